sirv_queue_sched: RTL and testbench

Scheduler/controller wrapped around one 8-entry byte FIFO instance (enq/deq/count interface). Shares the FIFO enqueue port between two byte producers with round-robin arbitration. Sequences a flush that drains the FIFO while isolating the downstream consumer. Generates a registered low-watermark indication from the FIFO count. Sits between the peripheral's register/DMA byte sources and its TX queue, and between the queue and the shifter.

---
 rtl/sirv_queue_sched_if.sv | 41 ++++
 rtl/sirv_queue_sched.sv | 84 ++++++++
 tb/tb_sirv_queue_sched.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/sirv_queue_sched_if.sv
// Handshake bundle between the queue scheduler and its producers, FIFO and consumer.
// The slave modport is the scheduler's view; master is the surrounding environment.
interface sirv_queue_sched_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned CW = 4
);
  logic          io_req0_valid;
  logic          io_req0_ready;
  logic [DW-1:0] io_req0_bits;
  logic          io_req1_valid;
  logic          io_req1_ready;
  logic [DW-1:0] io_req1_bits;
  logic          io_q_enq_valid;
  logic          io_q_enq_ready;
  logic [DW-1:0] io_q_enq_bits;
  logic          io_q_deq_valid;
  logic          io_q_deq_ready;
  logic [CW-1:0] io_q_count;
  logic          io_cons_valid;
  logic          io_cons_ready;
  logic          io_flush_req;
  logic          io_flush_busy;
  logic [CW-1:0] io_txwm;
  logic          io_ip_txwm;

  modport slave (
    input  io_req0_valid, io_req0_bits, io_req1_valid, io_req1_bits,
    input  io_q_enq_ready, io_q_deq_valid, io_q_count, io_cons_ready,
    input  io_flush_req, io_txwm,
    output io_req0_ready, io_req1_ready, io_q_enq_valid, io_q_enq_bits,
    output io_q_deq_ready, io_cons_valid, io_flush_busy, io_ip_txwm
  );

  modport master (
    output io_req0_valid, io_req0_bits, io_req1_valid, io_req1_bits,
    output io_q_enq_ready, io_q_deq_valid, io_q_count, io_cons_ready,
    output io_flush_req, io_txwm,
    input  io_req0_ready, io_req1_ready, io_q_enq_valid, io_q_enq_bits,
    input  io_q_deq_ready, io_cons_valid, io_flush_busy, io_ip_txwm
  );
endinterface

// File: rtl/sirv_queue_sched.sv
// TX queue scheduler: round-robin enqueue arbitration between two byte producers,
// flush sequencing that drains the FIFO away from the consumer, and low-watermark flag.
module sirv_queue_sched #(
  parameter int unsigned DW = 8,
  parameter int unsigned CW = 4
) (
  input  logic              clock,
  input  logic              reset,
  sirv_queue_sched_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StFlush} state_e;

  state_e        r_state;
  state_e        w_state_next;
  logic          r_rr_last;
  logic          r_ip_txwm;
  logic          w_any_valid;
  logic          w_grant0;
  logic          w_grant1;
  logic          w_accept;
  logic [DW-1:0] w_bits;

  // rr_last names the requester served last, so on a tie the other one wins.
  assign w_any_valid = bus.io_req0_valid | bus.io_req1_valid;
  assign w_grant1    = bus.io_req1_valid & (~bus.io_req0_valid | ~r_rr_last);
  assign w_grant0    = bus.io_req0_valid & ~w_grant1;
  assign w_bits      = w_grant1 ? bus.io_req1_bits : bus.io_req0_bits;
  assign w_accept    = (r_state == StIdle) & w_any_valid & bus.io_q_enq_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (bus.io_flush_req) w_state_next = StFlush;
      StFlush: if ((bus.io_q_count == '0) && !bus.io_q_deq_valid) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    bus.io_q_enq_valid = 1'b0;
    bus.io_q_enq_bits  = w_bits;
    bus.io_req0_ready  = 1'b0;
    bus.io_req1_ready  = 1'b0;
    bus.io_q_deq_ready = 1'b0;
    bus.io_cons_valid  = 1'b0;
    unique case (r_state)
      StIdle: begin
        bus.io_q_enq_valid = w_any_valid;
        bus.io_req0_ready  = w_grant0 & bus.io_q_enq_ready;
        bus.io_req1_ready  = w_grant1 & bus.io_q_enq_ready;
        bus.io_q_deq_ready = bus.io_cons_ready;
        bus.io_cons_valid  = bus.io_q_deq_valid;
      end
      StFlush: begin
        // Drain and discard; the consumer never sees these bytes.
        bus.io_q_deq_ready = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rr_last <= 1'b1;
      r_ip_txwm <= 1'b0;
    end else begin
      if (w_accept) r_rr_last <= w_grant1;
      r_ip_txwm <= (bus.io_q_count < bus.io_txwm);
    end
  end

  assign bus.io_flush_busy = (r_state == StFlush);
  assign bus.io_ip_txwm    = r_ip_txwm;

endmodule

// File: tb/tb_sirv_queue_sched.sv
// Bench for sirv_queue_sched: a byte-queue FIFO environment plus a rule-level model of
// arbitration, flush and watermark, compared against the DUT every cycle.
module tb_sirv_queue_sched;

  logic clock = 1'b0;
  logic reset = 1'b0;

  sirv_queue_sched_if #(.DW(8), .CW(4)) bus ();

  sirv_queue_sched #(.DW(8), .CW(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int unsigned errors = 0;
  int unsigned checks = 0;
  logic [7:0]  fifo[$];
  bit          m_flush = 1'b0;
  bit          m_last  = 1'b1;
  bit          m_wm    = 1'b0;
  bit          stall   = 1'b0;
  bit          last_acc;
  bit          last_pick;
  int unsigned busy_seen;
  logic [7:0]  a_idx, b_idx;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One clock: present FIFO state, check DUT against model, then advance both.
  task automatic cycle();
    logic [3:0] cnt;
    bit v0, v1, any, pick, enq_rdy, dv, acc, deq;
    cnt     = 4'(fifo.size());
    enq_rdy = (fifo.size() < 8) && !stall;
    dv      = fifo.size() > 0;
    bus.io_q_count     = cnt;
    bus.io_q_enq_ready = enq_rdy;
    bus.io_q_deq_valid = dv;
    #2;
    v0   = bus.io_req0_valid;
    v1   = bus.io_req1_valid;
    any  = v0 || v1;
    pick = (v0 && v1) ? !m_last : !v0;
    if (!reset) begin
      chk("busy", 8'(bus.io_flush_busy), 8'(m_flush));
      chk("ip_txwm", 8'(bus.io_ip_txwm), 8'(m_wm));
      chk("enq_valid", 8'(bus.io_q_enq_valid), 8'(!m_flush && any));
      if (!m_flush && any) chk("enq_bits", bus.io_q_enq_bits, pick ? bus.io_req1_bits : bus.io_req0_bits);
      chk("req0_ready", 8'(bus.io_req0_ready), 8'(!m_flush && v0 && !pick && enq_rdy));
      chk("req1_ready", 8'(bus.io_req1_ready), 8'(!m_flush && v1 && pick && enq_rdy));
      chk("deq_ready", 8'(bus.io_q_deq_ready), 8'(m_flush ? 1'b1 : bus.io_cons_ready));
      chk("cons_valid", 8'(bus.io_cons_valid), 8'(!m_flush && dv));
      if (bus.io_flush_busy === 1'b1) busy_seen++;
    end
    @(posedge clock);
    acc = !m_flush && any && enq_rdy;
    deq = dv && (m_flush || bus.io_cons_ready);
    if (deq) void'(fifo.pop_front());
    if (acc) fifo.push_back(pick ? bus.io_req1_bits : bus.io_req0_bits);
    last_acc  = acc;
    last_pick = pick;
    if (reset) begin
      m_flush = 1'b0;
      m_last  = 1'b1;
      m_wm    = 1'b0;
    end else begin
      m_wm = cnt < bus.io_txwm;
      if (acc) m_last = pick;
      if (!m_flush) m_flush = bus.io_flush_req;
      else if (cnt == 0 && !dv) m_flush = 1'b0;
    end
    #1;
  endtask

  task automatic advance_bits();
    if (last_acc && !last_pick) begin a_idx++; bus.io_req0_bits = 8'hA0 + a_idx; end
    if (last_acc && last_pick)  begin b_idx++; bus.io_req1_bits = 8'hB0 + b_idx; end
  endtask

  initial begin
    bus.io_req0_valid = 1'b0;
    bus.io_req0_bits  = 8'h00;
    bus.io_req1_valid = 1'b0;
    bus.io_req1_bits  = 8'h00;
    bus.io_cons_ready = 1'b0;
    bus.io_flush_req  = 1'b0;
    bus.io_txwm       = 4'd0;
    bus.io_q_count    = 4'd0;
    bus.io_q_enq_ready = 1'b1;
    bus.io_q_deq_valid = 1'b0;
    @(negedge clock);

    reset = 1'b1;
    cycle();
    reset = 1'b0;

    // Two bytes from requester 0.
    bus.io_req0_valid = 1'b1;
    bus.io_req0_bits  = 8'h11;
    cycle();
    bus.io_req0_bits  = 8'h22;
    cycle();
    bus.io_req0_valid = 1'b0;
    chk("two_bytes_len", 8'(fifo.size()), 8'd2);
    bus.io_cons_ready = 1'b1;
    repeat (3) cycle();
    bus.io_cons_ready = 1'b0;

    // Both requesters contend, then a 3-cycle FIFO stall mid-stream.
    a_idx = 0; b_idx = 0;
    bus.io_req0_bits = 8'hA0; bus.io_req1_bits = 8'hB0;
    bus.io_req0_valid = 1'b1; bus.io_req1_valid = 1'b1;
    repeat (3) begin cycle(); advance_bits(); end
    stall = 1'b1;
    repeat (3) begin cycle(); advance_bits(); end
    stall = 1'b0;
    repeat (3) begin cycle(); advance_bits(); end
    bus.io_req0_valid = 1'b0; bus.io_req1_valid = 1'b0;
    chk("rr_seq_len", 8'(fifo.size()), 8'd6);
    chk("rr_seq_a", a_idx, 8'd3);
    chk("rr_seq_b", b_idx, 8'd3);
    bus.io_cons_ready = 1'b1;
    repeat (8) cycle();
    bus.io_cons_ready = 1'b0;

    // Flush with 5 bytes queued.
    bus.io_req0_valid = 1'b1;
    repeat (5) cycle();
    bus.io_req0_valid = 1'b0;
    busy_seen = 0;
    bus.io_flush_req = 1'b1;
    cycle();
    bus.io_flush_req = 1'b0;
    repeat (10) cycle();
    chk("flush5_busy_cycles", 8'(busy_seen), 8'd6);

    // Empty flush, with a second request while busy.
    busy_seen = 0;
    bus.io_flush_req = 1'b1;
    cycle();
    cycle();
    bus.io_flush_req = 1'b0;
    repeat (4) cycle();
    chk("flush0_busy_cycles", 8'(busy_seen), 8'd1);

    // Watermark sweep with count 0..8.
    bus.io_txwm = 4'd4;
    bus.io_req0_valid = 1'b1;
    repeat (8) cycle();
    bus.io_req0_valid = 1'b0;
    repeat (2) cycle();
    bus.io_txwm = 4'd0;
    repeat (3) cycle();
    bus.io_txwm = 4'd9;
    repeat (3) cycle();
    chk("wm_full_count", 8'(fifo.size()), 8'd8);

    // Reset while flushing with 3 bytes left.
    bus.io_flush_req = 1'b1;
    cycle();
    bus.io_flush_req = 1'b0;
    for (int g = 0; g < 20 && fifo.size() != 3; g++) cycle();
    chk("midflush_count", 8'(fifo.size()), 8'd3);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    cycle();
    chk("post_reset_busy", 8'(bus.io_flush_busy), 8'd0);
    bus.io_cons_ready = 1'b1;
    repeat (4) cycle();

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      bus.io_req0_valid = 1'($urandom_range(0, 1));
      bus.io_req1_valid = 1'($urandom_range(0, 1));
      bus.io_req0_bits  = 8'($urandom);
      bus.io_req1_bits  = 8'($urandom);
      bus.io_cons_ready = 1'($urandom_range(0, 1));
      bus.io_flush_req  = ($urandom_range(0, 15) == 0);
      stall             = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 31) == 0) bus.io_txwm = 4'($urandom_range(0, 15));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
